// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage and a host
// debug port; one access per cycle, read data returned one cycle after grant.
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              RN,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  core_wait_cnt
);
    typedef enum logic [0:0] {ARB = 1'b0, LOCK = 1'b1} state_t;
    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    state_t            state_r, state_nxt_s;
    logic              last_gnt_r;
    logic              tag_valid_r, tag_owner_r;
    logic [DATA_W-1:0] core_hold_r, dbg_hold_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              core_pick_s, dbg_pick_s;
    logic              core_gnt_s, dbg_gnt_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    // Round-robin pick: on a tie the requester that did not win last time goes.
    function automatic logic [1:0] arb_pick(input logic creq, input logic dreq, input logic last);
        logic [1:0] pick;
        if (creq && dreq) begin
            pick = (last == OWN_DBG) ? 2'b10 : 2'b01;
        end else begin
            pick = {creq, dreq};
        end
        return pick;
    endfunction

    // Grant selection and lock state transitions
    always_comb begin
        state_nxt_s = state_r;
        core_pick_s = 1'b0;
        dbg_pick_s  = 1'b0;
        case (state_r)
            LOCK: begin
                if (dbg_lock) begin
                    dbg_pick_s  = dbg_req;
                    core_pick_s = core_req & ~dbg_req;
                    state_nxt_s = LOCK;
                end else begin
                    {core_pick_s, dbg_pick_s} = arb_pick(core_req, dbg_req, last_gnt_r);
                    state_nxt_s = ARB;
                end
            end
            ARB: begin
                {core_pick_s, dbg_pick_s} = arb_pick(core_req, dbg_req, last_gnt_r);
                state_nxt_s = (dbg_pick_s && dbg_lock) ? LOCK : ARB;
            end
            default: begin
                state_nxt_s = ARB;
            end
        endcase
    end

    // Nothing is granted while reset is held.
    assign core_gnt_s = core_pick_s & RN;
    assign dbg_gnt_s  = dbg_pick_s & RN;

    // Memory request mux driven by the granted requester
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        if (core_gnt_s) begin
            mem_we_s    = core_we;
            mem_addr_s  = core_addr;
            mem_wdata_s = core_wdata;
        end else if (dbg_gnt_s) begin
            mem_we_s    = dbg_we;
            mem_addr_s  = dbg_addr;
            mem_wdata_s = dbg_wdata;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Arbitration state and fairness pointer
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_r    <= ARB;
            last_gnt_r <= OWN_DBG;
        end else begin
            state_r <= state_nxt_s;
            if (core_gnt_s || dbg_gnt_s) begin
                last_gnt_r <= dbg_gnt_s;
            end
        end
    end

    // Read-return tag and per-owner data hold registers
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            tag_valid_r <= 1'b0;
            tag_owner_r <= OWN_CORE;
            core_hold_r <= {DATA_W{1'b0}};
            dbg_hold_r  <= {DATA_W{1'b0}};
        end else begin
            tag_valid_r <= (core_gnt_s | dbg_gnt_s) & ~mem_we_s;
            tag_owner_r <= dbg_gnt_s;
            if (tag_valid_r && (tag_owner_r == OWN_CORE)) begin
                core_hold_r <= mem_rdata;
            end
            if (tag_valid_r && (tag_owner_r == OWN_DBG)) begin
                dbg_hold_r <= mem_rdata;
            end
        end
    end

    // Saturating count of core stall cycles
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (core_stall && (wait_cnt_r != {CNT_W{1'b1}})) begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign core_gnt      = core_gnt_s;
    assign dbg_gnt       = dbg_gnt_s;
    assign core_stall    = RN & core_req & ~core_gnt_s;
    assign mem_en        = core_gnt_s | dbg_gnt_s;
    assign mem_we        = mem_we_s;
    assign mem_addr      = mem_addr_s;
    assign mem_wdata     = mem_wdata_s;
    assign core_rvalid   = tag_valid_r & (tag_owner_r == OWN_CORE);
    assign dbg_rvalid    = tag_valid_r & (tag_owner_r == OWN_DBG);
    assign core_rdata    = core_rvalid ? mem_rdata : core_hold_r;
    assign dbg_rdata     = dbg_rvalid ? mem_rdata : dbg_hold_r;
    assign core_wait_cnt = wait_cnt_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset/lock corner sequences,
// random traffic against a transaction-level model, and counter saturation.
module tb_dmem_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rn  = 1'b0;
    always #5 clk = ~clk;

    logic          core_req, core_we, dbg_req, dbg_we, dbg_lock;
    logic [AW-1:0] core_addr, dbg_addr;
    logic [DW-1:0] core_wdata, dbg_wdata;
    logic          core_gnt, core_rvalid, core_stall, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] core_rdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [CW-1:0] core_wait_cnt;

    logic          sat_req = 1'b0;
    logic          sat_core_gnt, sat_core_rvalid, sat_core_stall, sat_dbg_gnt, sat_dbg_rvalid;
    logic [DW-1:0] sat_core_rdata, sat_dbg_rdata, sat_mem_wdata;
    logic          sat_mem_en, sat_mem_we;
    logic [AW-1:0] sat_mem_addr;
    logic [3:0]    sat_cnt;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .RN(rn),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .core_wait_cnt(core_wait_cnt)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dut_sat (
        .clk(clk), .RN(rn),
        .core_req(sat_req), .core_we(1'b0), .core_addr(5'd0), .core_wdata(32'd0),
        .core_gnt(sat_core_gnt), .core_rvalid(sat_core_rvalid), .core_rdata(sat_core_rdata),
        .core_stall(sat_core_stall),
        .dbg_req(sat_req), .dbg_we(1'b0), .dbg_addr(5'd0), .dbg_wdata(32'd0),
        .dbg_lock(sat_req), .dbg_gnt(sat_dbg_gnt), .dbg_rvalid(sat_dbg_rvalid), .dbg_rdata(sat_dbg_rdata),
        .mem_en(sat_mem_en), .mem_we(sat_mem_we), .mem_addr(sat_mem_addr), .mem_wdata(sat_mem_wdata),
        .mem_rdata(32'd0), .core_wait_cnt(sat_cnt)
    );

    // Synchronous 32x32 memory, preloaded with mem[i] = i
    logic [DW-1:0] mem [32];
    bit            mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= DW'(i);
            mem_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus, what each port is owed, and a shadow memory
    bit            m_last_dbg, m_locked, m_tag_valid, m_tag_core;
    logic [DW-1:0] m_tag_data, m_core_hold, m_dbg_hold;
    int            m_cnt;
    logic [DW-1:0] sm [32];
    bit            e_cg, e_dg;

    typedef struct {
        bit            rst;
        bit            creq, cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        bit            dreq, dwe;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwd;
        bit            dlk;
        bit            ecg, edg, ecv, edv;
        logic [DW-1:0] erd;
        int            ecnt;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(bit rst, bit creq, bit cwe, int caddr, logic [DW-1:0] cwd,
                                bit dreq, bit dwe, int daddr, logic [DW-1:0] dwd, bit dlk,
                                bit ecg, bit edg, bit ecv, bit edv, logic [DW-1:0] erd, int ecnt);
        vec_t v;
        v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = AW'(caddr); v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.daddr = AW'(daddr); v.dwd = dwd; v.dlk = dlk;
        v.ecg = ecg; v.edg = edg; v.ecv = ecv; v.edv = edv; v.erd = erd; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_last_dbg = 1'b1; m_locked = 1'b0; m_tag_valid = 1'b0; m_tag_core = 1'b0;
        m_tag_data = '0; m_core_hold = '0; m_dbg_hold = '0; m_cnt = 0;
    endtask

    task automatic zero_inputs();
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 1'b0;
    endtask

    // Mid-cycle: predict the grants and compare every observable output.
    task automatic model_eval();
        bit cv, dv;
        #4;
        if (m_locked && dbg_lock) begin
            e_dg = dbg_req;
            e_cg = core_req && !dbg_req;
        end else if (core_req && dbg_req) begin
            e_cg = m_last_dbg;
            e_dg = !m_last_dbg;
        end else begin
            e_cg = core_req;
            e_dg = dbg_req;
        end
        cv = m_tag_valid && m_tag_core;
        dv = m_tag_valid && !m_tag_core;
        chk("core_gnt", core_gnt, e_cg);
        chk("dbg_gnt", dbg_gnt, e_dg);
        chk("core_stall", core_stall, core_req && !e_cg);
        chk("mem_en", mem_en, e_cg || e_dg);
        if (e_cg || e_dg) begin
            chk("mem_we", mem_we, e_cg ? core_we : dbg_we);
            chk("mem_addr", mem_addr, e_cg ? core_addr : dbg_addr);
            if (mem_we) chk("mem_wdata", mem_wdata, e_cg ? core_wdata : dbg_wdata);
        end else begin
            chk("mem_we_idle", mem_we, 1'b0);
        end
        chk("core_rvalid", core_rvalid, cv);
        chk("dbg_rvalid", dbg_rvalid, dv);
        chk("core_rdata", core_rdata, cv ? m_tag_data : m_core_hold);
        chk("dbg_rdata", dbg_rdata, dv ? m_tag_data : m_dbg_hold);
        chk("wait_cnt", core_wait_cnt, DW'(m_cnt));
    endtask

    task automatic model_update();
        bit            we;
        logic [AW-1:0] a;
        if (m_tag_valid) begin
            if (m_tag_core) m_core_hold = m_tag_data;
            else            m_dbg_hold  = m_tag_data;
        end
        m_tag_valid = 1'b0;
        if (e_cg || e_dg) begin
            we = e_cg ? core_we : dbg_we;
            a  = e_cg ? core_addr : dbg_addr;
            m_last_dbg = e_dg;
            if (we) begin
                sm[a] = e_cg ? core_wdata : dbg_wdata;
            end else begin
                m_tag_valid = 1'b1;
                m_tag_core  = e_cg;
                m_tag_data  = sm[a];
            end
        end
        m_locked = dbg_lock && (m_locked || e_dg);
        if (core_req && !e_cg && m_cnt < 65535) m_cnt++;
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Hold reset for two edges; everything observable must read zero meanwhile.
    task automatic do_reset();
        rn = 1'b0;
        zero_inputs();
        #4;
        chk("rst_core_gnt", core_gnt, 1'b0);
        chk("rst_dbg_gnt", dbg_gnt, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_core_stall", core_stall, 1'b0);
        chk("rst_core_rvalid", core_rvalid, 1'b0);
        chk("rst_dbg_rvalid", dbg_rvalid, 1'b0);
        chk("rst_core_rdata", core_rdata, '0);
        chk("rst_dbg_rdata", dbg_rdata, '0);
        chk("rst_wait_cnt", core_wait_cnt, '0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rn = 1'b1;
    endtask

    initial begin
        zero_inputs();
        for (int i = 0; i < 32; i++) sm[i] = DW'(i);
        model_reset();

        //            rst creq cwe ca cwd            dreq dwe da dwd         dlk cg dg cv dv erd        cnt
        tv.push_back(mk(1, 1, 0, 3, 32'h0,          0, 0, 0, 32'h0,        0,  1, 0, 0, 0, 32'h0,     0));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h0,        0,  0, 0, 1, 0, 32'h3,    -1));
        tv.push_back(mk(1, 1, 0, 5, 32'h0,          1, 0, 6, 32'h0,        0,  1, 0, 0, 0, 32'h0,     0));
        tv.push_back(mk(0, 1, 0, 5, 32'h0,          1, 0, 6, 32'h0,        0,  0, 1, 1, 0, 32'h5,    -1));
        tv.push_back(mk(0, 1, 0, 5, 32'h0,          1, 0, 6, 32'h0,        0,  1, 0, 0, 1, 32'h6,    -1));
        tv.push_back(mk(0, 1, 0, 5, 32'h0,          1, 0, 6, 32'h0,        0,  0, 1, 1, 0, 32'h5,    -1));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h0,        0,  0, 0, 0, 1, 32'h6,     2));
        tv.push_back(mk(1, 1, 1, 10, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,        0,  1, 0, 0, 0, 32'h0,     0));
        tv.push_back(mk(0, 1, 0, 7, 32'h0,          1, 1, 0, 32'hA0,       1,  0, 1, 0, 0, 32'h0,    -1));
        tv.push_back(mk(0, 1, 0, 7, 32'h0,          1, 1, 1, 32'hA1,       1,  0, 1, 0, 0, 32'h0,    -1));
        tv.push_back(mk(0, 1, 0, 7, 32'h0,          1, 1, 2, 32'hA2,       1,  0, 1, 0, 0, 32'h0,    -1));
        tv.push_back(mk(0, 1, 0, 7, 32'h0,          1, 1, 3, 32'hA3,       1,  0, 1, 0, 0, 32'h0,    -1));
        tv.push_back(mk(0, 1, 0, 7, 32'h0,          0, 0, 0, 32'h0,        0,  1, 0, 0, 0, 32'h0,     4));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,          1, 1, 1, 32'h11,       0,  0, 1, 1, 0, 32'h7,    -1));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,          1, 1, 2, 32'h22,       0,  0, 1, 0, 0, 32'h0,    -1));
        tv.push_back(mk(0, 1, 0, 1, 32'h0,          0, 0, 0, 32'h0,        0,  1, 0, 0, 0, 32'h0,    -1));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,          1, 0, 2, 32'h0,        0,  0, 1, 1, 0, 32'h11,   -1));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h0,        0,  0, 0, 0, 1, 32'h22,   -1));

        @(posedge clk);
        #1;
        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rst) do_reset();
            core_req = tv[i].creq; core_we = tv[i].cwe; core_addr = tv[i].caddr; core_wdata = tv[i].cwd;
            dbg_req = tv[i].dreq; dbg_we = tv[i].dwe; dbg_addr = tv[i].daddr; dbg_wdata = tv[i].dwd;
            dbg_lock = tv[i].dlk;
            model_eval();
            chk($sformatf("tv%0d_core_gnt", i), core_gnt, tv[i].ecg);
            chk($sformatf("tv%0d_dbg_gnt", i), dbg_gnt, tv[i].edg);
            chk($sformatf("tv%0d_core_rvalid", i), core_rvalid, tv[i].ecv);
            chk($sformatf("tv%0d_dbg_rvalid", i), dbg_rvalid, tv[i].edv);
            if (tv[i].ecv) chk($sformatf("tv%0d_core_rdata", i), core_rdata, tv[i].erd);
            if (tv[i].edv) chk($sformatf("tv%0d_dbg_rdata", i), dbg_rdata, tv[i].erd);
            if (tv[i].ecnt >= 0) chk($sformatf("tv%0d_wait_cnt", i), core_wait_cnt, DW'(tv[i].ecnt));
            advance();
        end

        // Enter LOCK, grant a core read, then reset before its data returns.
        do_reset();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h9999_0000; dbg_lock = 1'b1;
        model_eval();
        chk("lk_dbg_gnt", dbg_gnt, 1'b1);
        advance();
        dbg_req = 1'b0; core_req = 1'b1; core_we = 1'b0; core_addr = 5'd4;
        model_eval();
        chk("lk_core_gnt_idle_dbg", core_gnt, 1'b1);
        advance();
        do_reset();
        core_req = 1'b1; dbg_req = 1'b1; dbg_lock = 1'b1; core_addr = 5'd9; dbg_addr = 5'd0;
        model_eval();
        chk("post_rst_tie_core", core_gnt, 1'b1);
        chk("post_rst_tie_dbg", dbg_gnt, 1'b0);
        advance();
        zero_inputs();
        model_eval();
        chk("post_rst_rdata", core_rdata, 32'h9999_0000);
        advance();

        // Random traffic; an ungranted request keeps its fields until granted.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (!(core_req && !e_cg)) begin
                core_req = ($urandom_range(0, 3) != 0);
                core_we = ($urandom_range(0, 2) == 0);
                core_addr = AW'($urandom_range(0, 31));
                core_wdata = $urandom;
            end
            if (!(dbg_req && !e_dg)) begin
                dbg_req = ($urandom_range(0, 2) != 0);
                dbg_we = ($urandom_range(0, 1) == 0);
                dbg_addr = AW'($urandom_range(0, 31));
                dbg_wdata = $urandom;
            end
            if ($urandom_range(0, 7) == 0) dbg_lock = !dbg_lock;
            model_eval();
            advance();
        end

        // Narrow counter: core stalled from the second cycle onward must stick at 15.
        do_reset();
        sat_req = 1'b1;
        for (int n = 0; n < 26; n++) begin
            #4;
            chk($sformatf("sat_cnt_%0d", n), DW'(sat_cnt), DW'((n == 0) ? 0 : ((n - 1 > 15) ? 15 : n - 1)));
            @(posedge clk);
            #1;
        end
        sat_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
